// File: rtl/dpwm_pkg.sv
// ---------------------------------------------------------------------------
// dpwm_pkg
//   Definitions shared by the hybrid DPWM top and its phase scheduler:
//   the scheduler state encoding, the fine (decoder select) width, and the
//   bit positions of the coarse and fine fields inside a duty word.
//   Duty word layout: [COARSE_LSB +: CNT_W] coarse count, [FINE_LSB +: FINE_W] fine phase.
// ---------------------------------------------------------------------------
package dpwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } dpwm_state_e;

  // Width of the 2-to-4 phase decoder select; the decoder has exactly four phases.
  localparam int DPWM_FINE_W = 2;

  // Field positions inside a duty command word.
  localparam int DUTY_FINE_LSB   = 0;
  localparam int DUTY_COARSE_LSB = DPWM_FINE_W;

endpackage

// File: rtl/dpwm_duty_buffer.sv
// ---------------------------------------------------------------------------
// dpwm_duty_buffer
//   Pending/active double buffer for duty commands. A write always lands in
//   the pending register (last write wins). When the scheduler signals a
//   period start and a pending value exists, the pending value becomes
//   active and a one-cycle acknowledge pulse is registered.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   i_duty_wr     in   duty load strobe
//   i_duty        in   duty command word
//   i_xfer        in   period-start cycle (transfer opportunity)
//   o_active_eff  out  duty in force for the current cycle (includes a
//                      transfer happening on this very cycle)
//   o_ack         out  registered pulse: pending transferred to active
// ---------------------------------------------------------------------------
module dpwm_duty_buffer
  import dpwm_pkg::*;
#(
  parameter int DUTY_W = 4 + DPWM_FINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_duty_wr,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic              i_xfer,
  output logic [DUTY_W-1:0] o_active_eff,
  output logic              o_ack
);

  logic [DUTY_W-1:0] r_pend;
  logic              r_pend_v;
  logic [DUTY_W-1:0] r_active;
  logic              r_ack;
  logic              w_take;

  assign w_take = i_xfer && r_pend_v;

  // The compare on a period-start cycle must already see the incoming value,
  // otherwise a coarse==0 duty would miss its first enable.
  assign o_active_eff = w_take ? r_pend : r_active;
  assign o_ack        = r_ack;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_active <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_take;
      if (w_take) begin
        r_active <= r_pend;
      end
      // A write coincident with a transfer refills pending after the old
      // value has moved to active, so the new command stays valid.
      if (i_duty_wr) begin
        r_pend   <= i_duty;
        r_pend_v <= 1'b1;
      end else if (w_take) begin
        r_pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dpwm_phase_scheduler.sv
// ---------------------------------------------------------------------------
// dpwm_phase_scheduler
//   Period/duty sequencer for the hybrid DPWM. A free-running coarse counter
//   defines a period of 2**CNT_W cycles. At each period start the PWM latch is
//   set and any buffered duty command is applied. When the count matches the
//   active coarse duty, the 2-to-4 phase decoder is enabled for one cycle with
//   the fine phase on its select, which resets the PWM latch at a sub-cycle
//   position. All decoder/latch outputs are registered (one cycle latency).
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset, overrides everything
//   en        in   run request
//   duty      in   duty command: [CNT_W+1:2] coarse, [1:0] fine phase
//   duty_wr   in   duty load strobe (one cycle)
//   duty_ack  out  pulse: pending duty became active (with pwm_set)
//   dec_sel   out  decoder fine phase select (holds between enables)
//   dec_rst   out  decoder reset, 1 = decoder outputs forced off
//   pwm_set   out  pulse at period start
//   busy      out  1 while running or finishing the last period
//   cnt       out  current coarse count
// ---------------------------------------------------------------------------
module dpwm_phase_scheduler
  import dpwm_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int FINE_W = DPWM_FINE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_W+FINE_W-1:0] duty,
  input  logic                    duty_wr,
  output logic                    duty_ack,
  output logic [1:0]              dec_sel,
  output logic                    dec_rst,
  output logic                    pwm_set,
  output logic                    busy,
  output logic [CNT_W-1:0]        cnt
);

  localparam int               DUTY_W  = CNT_W + FINE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The decoder is a fixed 2-to-4 part; refuse to build anything else.
  if (FINE_W != 2) begin : g_fine_w_check
    $error("dpwm_phase_scheduler: FINE_W must be 2");
  end

  dpwm_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_dec_sel;
  logic              r_dec_rst;
  logic              r_pwm_set;
  logic              r_busy;

  logic              w_period_start;
  logic [DUTY_W-1:0] w_active_eff;
  logic [CNT_W-1:0]  w_coarse;
  logic [1:0]        w_fine;
  logic              w_hit;

  // Only RUN opens a new period; STOP merely finishes the current one.
  assign w_period_start = (r_state == ST_RUN) && (r_cnt == '0);

  dpwm_duty_buffer #(
    .DUTY_W (DUTY_W)
  ) u_duty_buffer (
    .clk          (clk),
    .rst          (rst),
    .i_duty_wr    (duty_wr),
    .i_duty       (duty),
    .i_xfer       (w_period_start),
    .o_active_eff (w_active_eff),
    .o_ack        (duty_ack)
  );

  assign w_coarse = w_active_eff[DUTY_COARSE_LSB +: CNT_W];
  assign w_fine   = w_active_eff[DUTY_FINE_LSB +: 2];

  // A zero duty word means 0% duty: the decoder is never enabled.
  assign w_hit = (r_state != ST_IDLE) && (w_active_eff != '0) && (r_cnt == w_coarse);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dec_sel <= 2'd0;
      r_dec_rst <= 1'b1;
      r_pwm_set <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_pwm_set <= w_period_start;

      if (w_hit) begin
        r_dec_rst <= 1'b0;
        r_dec_sel <= w_fine;
      end else begin
        r_dec_rst <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // Counter stays at 0 so the first RUN cycle is a period start.
          r_cnt <= '0;
          if (en) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (!en) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_cnt <= r_cnt + 1'b1;
          if (en) begin
            r_state <= ST_RUN;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dec_sel = r_dec_sel;
  assign dec_rst = r_dec_rst;
  assign pwm_set = r_pwm_set;
  assign busy    = r_busy;
  assign cnt     = r_cnt;

endmodule

// File: tb/tb_dpwm_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dpwm_phase_scheduler
//   Directed scenarios for the phase scheduler (reset, buffered duty, last
//   write wins, coincident write, 0% duty, coarse 0/max, en drop, mid-period
//   reset) followed by randomized traffic compared against a behavioural
//   model that tracks mode, period position and a queue of pending commands.
// ---------------------------------------------------------------------------
module tb_dpwm_phase_scheduler;

  localparam int CNT_W  = 4;
  localparam int DW     = CNT_W + 2;
  localparam int PERIOD = 1 << CNT_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          duty_wr;
  logic [DW-1:0] duty;
  logic          duty_ack;
  logic [1:0]    dec_sel;
  logic          dec_rst;
  logic          pwm_set;
  logic          busy;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpwm_phase_scheduler #(
    .CNT_W  (CNT_W),
    .FINE_W (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .duty     (duty),
    .duty_wr  (duty_wr),
    .duty_ack (duty_ack),
    .dec_sel  (dec_sel),
    .dec_rst  (dec_rst),
    .pwm_set  (pwm_set),
    .busy     (busy),
    .cnt      (cnt)
  );

  // ------------------------------------------------------------------------
  // Reference model: mode of operation, position inside the period, the duty
  // in force and a queue of commands written since the last period start.
  // x_* hold the outputs expected after the edge just modelled.
  // ------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_RUN, M_STOP} mode_t;

  mode_t         m_mode   = M_IDLE;
  int            m_pos    = 0;
  logic [DW-1:0] m_active = '0;
  logic [DW-1:0] m_pend_q[$];

  logic       x_ack  = 1'b0;
  logic       x_pwm  = 1'b0;
  logic       x_rst  = 1'b1;
  logic [1:0] x_sel  = 2'd0;
  int         x_cnt  = 0;
  logic       x_busy = 1'b0;

  task automatic model_step(input logic r, input logic e, input logic w, input logic [DW-1:0] d);
    bit starts;
    if (r) begin
      m_mode = M_IDLE; m_pos = 0; m_active = '0; m_pend_q.delete();
      x_ack = 1'b0; x_pwm = 1'b0; x_rst = 1'b1; x_sel = 2'd0; x_cnt = 0; x_busy = 1'b0;
      return;
    end
    starts = (m_mode == M_RUN) && (m_pos == 0);
    x_ack  = 1'b0;
    if (starts && m_pend_q.size() != 0) begin
      m_active = m_pend_q[$];       // most recent command wins
      m_pend_q.delete();
      x_ack = 1'b1;
    end
    if (w) m_pend_q.push_back(d);
    x_pwm = starts;
    if (m_mode != M_IDLE && m_active != '0 && int'(m_active[DW-1:2]) == m_pos) begin
      x_rst = 1'b0;
      x_sel = m_active[1:0];
    end else begin
      x_rst = 1'b1;
    end
    case (m_mode)
      M_IDLE: if (e) m_mode = M_RUN;
      M_RUN: begin
        m_pos = (m_pos + 1) % PERIOD;
        if (!e) m_mode = M_STOP;
      end
      default: begin
        if (e) m_mode = M_RUN;
        else if (m_pos == PERIOD - 1) m_mode = M_IDLE;
        m_pos = (m_pos + 1) % PERIOD;
      end
    endcase
    x_cnt  = m_pos;
    x_busy = (m_mode != M_IDLE);
  endtask

  // One clock: drive inputs away from the edge, model the edge, sample #1 after.
  task automatic cycle(input logic r, input logic e, input logic w, input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; en = e; duty_wr = w; duty = d;
    @(posedge clk);
    model_step(r, e, w, d);
    #1;
  endtask

  // Runs with en=1 until pwm_set is seen; n = cycles taken, ok = seen in bound.
  task automatic wait_pwm(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 2 * PERIOD + 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      if (pwm_set) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starting on a sampled pwm_set (offset 0), records offsets 0..PERIOD-1 and
  // then steps onto the next period start (offset PERIOD). Writes are issued
  // on the edges producing offsets wa / wb (PERIOD = coincident with start).
  task automatic observe_period(input int wa, input logic [DW-1:0] da,
                                input int wb, input logic [DW-1:0] db,
                                output int n_dec, output int dec_off, output logic [1:0] dsel,
                                output int n_extra, output logic pwm_nx, output logic ack_nx);
    n_dec = 0; dec_off = -1; dsel = 2'd0; n_extra = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) begin
        cycle(1'b0, 1'b1, (k == wa) || (k == wb), (k == wb) ? db : da);
        if (pwm_set || duty_ack) n_extra++;
      end
      if (!dec_rst) begin
        n_dec++; dec_off = k; dsel = dec_sel;
      end
    end
    cycle(1'b0, 1'b1, (wa == PERIOD) || (wb == PERIOD), (wb == PERIOD) ? db : da);
    pwm_nx = pwm_set;
    ack_nx = duty_ack;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 6'h2A);
      checks++;
      if ({cnt, dec_sel, dec_rst, pwm_set, duty_ack, busy} !== {4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_values cyc%0d: got cnt=%0d sel=%0d drst=%0b pwm=%0b ack=%0b busy=%0b, expected 0/0/1/0/0/0",
                 i, cnt, dec_sel, dec_rst, pwm_set, duty_ack, busy);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (busy !== 1'b0 || duty_ack !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%0b ack=%0b, expected 0/0", busy, duty_ack);
    end
  endtask

  task automatic test_idle_write();
    int n; bit ok; int nd, doff, nx; logic [1:0] ds; logic pn, an;
    cycle(1'b0, 1'b0, 1'b1, 6'h16);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (busy !== 1'b1 || pwm_set !== 1'b0) begin
      errors++; $display("FAIL run_entry: busy=%0b pwm=%0b, expected 1/0", busy, pwm_set);
    end
    wait_pwm(n, ok);
    checks++;
    if (!ok || n != 1) begin
      errors++; $display("FAIL first_pwm_latency: got %0d cycles (seen=%0b), expected 1", n, ok);
    end
    checks++;
    if (duty_ack !== 1'b1 || cnt !== 4'd1) begin
      errors++; $display("FAIL first_ack: ack=%0b cnt=%0d, expected 1/1", duty_ack, cnt);
    end
    observe_period(-1, '0, -1, '0, nd, doff, ds, nx, pn, an);
    checks++;
    if (nd != 1 || doff != 5 || ds !== 2'd2 || nx != 0) begin
      errors++; $display("FAIL duty16_compare: n=%0d off=%0d sel=%0d extra=%0d, expected 1/5/2/0", nd, doff, ds, nx);
    end
    checks++;
    if (pn !== 1'b1 || an !== 1'b0) begin
      errors++; $display("FAIL duty16_next: pwm=%0b ack=%0b, expected 1/0", pn, an);
    end
  endtask

  task automatic test_last_write_wins();
    int nd, doff, nx; logic [1:0] ds; logic pn, an;
    observe_period(2, 6'h08, 6, 6'h3F, nd, doff, ds, nx, pn, an);
    checks++;
    if (nd != 1 || doff != 5 || nx != 0 || an !== 1'b1 || pn !== 1'b1) begin
      errors++; $display("FAIL two_writes: n=%0d off=%0d extra=%0d ack_next=%0b pwm_next=%0b, expected 1/5/0/1/1",
                         nd, doff, nx, an, pn);
    end
    observe_period(-1, '0, -1, '0, nd, doff, ds, nx, pn, an);
    checks++;
    if (nd != 1 || doff != 15 || ds !== 2'd3 || an !== 1'b0 || nx != 0) begin
      errors++; $display("FAIL duty3f_last_cycle: n=%0d off=%0d sel=%0d ack_next=%0b extra=%0d, expected 1/15/3/0/0",
                         nd, doff, ds, an, nx);
    end
  endtask

  task automatic test_back_to_back();
    int nd, doff, nx; logic [1:0] ds; logic pn, an;
    observe_period(3, 6'h04, PERIOD, 6'h0C, nd, doff, ds, nx, pn, an);
    checks++;
    if (an !== 1'b1) begin
      errors++; $display("FAIL coincident_ack_old: ack=%0b, expected 1", an);
    end
    observe_period(-1, '0, -1, '0, nd, doff, ds, nx, pn, an);
    checks++;
    if (nd != 1 || doff != 1 || ds !== 2'd0 || an !== 1'b1) begin
      errors++; $display("FAIL duty04_then_ack: n=%0d off=%0d sel=%0d ack_next=%0b, expected 1/1/0/1", nd, doff, ds, an);
    end
    observe_period(-1, '0, -1, '0, nd, doff, ds, nx, pn, an);
    checks++;
    if (nd != 1 || doff != 3 || an !== 1'b0) begin
      errors++; $display("FAIL duty0c_applied: n=%0d off=%0d ack_next=%0b, expected 1/3/0", nd, doff, an);
    end
  endtask

  task automatic test_zero_and_coarse0();
    int nd, doff, nx; logic [1:0] ds; logic pn, an;
    observe_period(4, 6'h00, -1, '0, nd, doff, ds, nx, pn, an);
    observe_period(4, 6'h02, -1, '0, nd, doff, ds, nx, pn, an);
    checks++;
    if (nd != 0 || pn !== 1'b1 || an !== 1'b1 || nx != 0) begin
      errors++; $display("FAIL zero_duty: n_dec=%0d pwm_next=%0b ack_next=%0b extra=%0d, expected 0/1/1/0", nd, pn, an, nx);
    end
    observe_period(-1, '0, -1, '0, nd, doff, ds, nx, pn, an);
    checks++;
    if (nd != 1 || doff != 0 || ds !== 2'd2) begin
      errors++; $display("FAIL coarse0_with_pwm: n=%0d off=%0d sel=%0d, expected 1/0/2", nd, doff, ds);
    end
  endtask

  task automatic test_en_drop();
    int nd, doff, nx; logic [1:0] ds; logic pn, an;
    int dec_at, npwm, last_busy;
    observe_period(5, 6'h28, -1, '0, nd, doff, ds, nx, pn, an);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (cnt !== 4'd3) begin
      errors++; $display("FAIL en_drop_align: cnt=%0d, expected 3", cnt);
    end
    dec_at = -1; npwm = 0; last_busy = -1;
    for (int k = 3; k < 3 + 2 * PERIOD; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      if (!dec_rst) dec_at = k;
      if (pwm_set) npwm++;
      if (busy) last_busy = k;
    end
    checks++;
    if (dec_at != 10 || dec_sel !== 2'd0) begin
      errors++; $display("FAIL en_drop_compare: off=%0d sel=%0d, expected 10/0", dec_at, dec_sel);
    end
    checks++;
    if (last_busy != 14 || npwm != 0 || cnt !== 4'd0) begin
      errors++; $display("FAIL en_drop_stop: last_busy=%0d pwm=%0d cnt=%0d, expected 14/0/0", last_busy, npwm, cnt);
    end
  endtask

  task automatic test_rst_mid_period();
    int n; bit ok; int nd, doff, nx; logic [1:0] ds; logic pn, an;
    cycle(1'b0, 1'b0, 1'b1, 6'h11);
    cycle(1'b0, 1'b1, 1'b0, '0);
    wait_pwm(n, ok);
    checks++;
    if (!ok || duty_ack !== 1'b1) begin
      errors++; $display("FAIL rst_setup_ack: seen=%0b ack=%0b, expected 1/1", ok, duty_ack);
    end
    cycle(1'b0, 1'b1, 1'b1, 6'h2C);
    for (int k = 2; k <= 8; k++) cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (cnt !== 4'd9) begin
      errors++; $display("FAIL rst_align: cnt=%0d, expected 9", cnt);
    end
    cycle(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if ({cnt, dec_sel, dec_rst, pwm_set, duty_ack, busy} !== {4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_values: got cnt=%0d sel=%0d drst=%0b pwm=%0b ack=%0b busy=%0b, expected 0/0/1/0/0/0",
               cnt, dec_sel, dec_rst, pwm_set, duty_ack, busy);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    wait_pwm(n, ok);
    checks++;
    if (!ok || duty_ack !== 1'b0) begin
      errors++; $display("FAIL rst_pend_cleared: seen=%0b ack=%0b, expected 1/0", ok, duty_ack);
    end
    observe_period(-1, '0, -1, '0, nd, doff, ds, nx, pn, an);
    checks++;
    if (nd != 0 || an !== 1'b0) begin
      errors++; $display("FAIL rst_active_cleared: n_dec=%0d ack_next=%0b, expected 0/0", nd, an);
    end
  endtask

  task automatic test_random();
    logic r, e, w;
    logic [DW-1:0] d;
    e = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) e = ~e;
      w = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 5))
        0:       d = '0;
        1:       d = {4'hF, 2'($urandom_range(0, 3))};
        2:       d = {4'h0, 2'($urandom_range(0, 3))};
        default: d = DW'($urandom);
      endcase
      cycle(r, e, w, d);
      checks++;
      if ({cnt, dec_sel, dec_rst, pwm_set, duty_ack, busy} !== {4'(x_cnt), x_sel, x_rst, x_pwm, x_ack, x_busy}) begin
        errors++;
        $display("FAIL random cyc%0d: got cnt=%0d sel=%0d drst=%0b pwm=%0b ack=%0b busy=%0b, expected %0d/%0d/%0b/%0b/%0b/%0b",
                 i, cnt, dec_sel, dec_rst, pwm_set, duty_ack, busy, x_cnt, x_sel, x_rst, x_pwm, x_ack, x_busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; duty_wr = 1'b1; duty = 6'h2A;
    test_reset();
    test_idle_write();
    test_last_write_wins();
    test_back_to_back();
    test_zero_and_coarse0();
    test_en_drop();
    test_rst_mid_period();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
